// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - PC stage control and result bundle
interface pc_next_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 stall_i;
  logic                 branch_taken_i;
  logic [31:0]          offset_sl2_i;
  logic                 jump_i;
  logic [27:0]          jump_addr_i;
  logic [31:0]          pc_o;
  logic [31:0]          pc_plus4_o;
  logic [31:0]          branch_target_o;
  logic                 flush_o;
  logic                 fault_o;
  logic [CNT_WIDTH-1:0] redirect_cnt_o;

  modport master (
    output stall_i, branch_taken_i, offset_sl2_i, jump_i, jump_addr_i,
    input  pc_o, pc_plus4_o, branch_target_o, flush_o, fault_o, redirect_cnt_o
  );

  modport slave (
    input  stall_i, branch_taken_i, offset_sl2_i, jump_i, jump_addr_i,
    output pc_o, pc_plus4_o, branch_target_o, flush_o, fault_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program counter with branch/jump select, flush, fault trap
module pc_next_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_next_unit_if.slave  bus_if
);
  typedef enum logic [1:0] {RUN, FLUSH, FAULT} state_e;

  state_e               state_q;
  logic [31:0]          pc_q;
  logic                 flush_q;
  logic                 fault_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [31:0]          pc_plus4;
  logic [31:0]          branch_target;
  logic [31:0]          jump_target;
  logic                 redirect_req;
  logic [31:0]          target_d;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + bus_if.offset_sl2_i;
  assign jump_target   = {pc_plus4[31:28], bus_if.jump_addr_i};

  // Jump wins over a simultaneous taken branch.
  always_comb begin
    redirect_req = bus_if.jump_i | bus_if.branch_taken_i;
    target_d     = bus_if.jump_i ? jump_target : branch_target;
    cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          flush_q <= 1'b0;
          if (!bus_if.stall_i) begin
            if (!redirect_req) begin
              pc_q <= pc_plus4;
            end else if (target_d[1:0] == 2'b00) begin
              pc_q    <= target_d;
              cnt_q   <= cnt_d;
              flush_q <= 1'b1;
              state_q <= FLUSH;
            end else begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end
          end
        end
        // Redirect inputs here belong to the squashed instruction.
        FLUSH: begin
          flush_q <= 1'b0;
          if (!bus_if.stall_i) pc_q <= pc_plus4;
          state_q <= RUN;
        end
        FAULT: begin
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.pc_o            = pc_q;
  assign bus_if.pc_plus4_o      = pc_plus4;
  assign bus_if.branch_target_o = branch_target;
  assign bus_if.flush_o         = flush_q;
  assign bus_if.fault_o         = fault_q;
  assign bus_if.redirect_cnt_o  = cnt_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - directed-vector bench for pc_next_unit
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   vec_cnt = 0;
  int   miss_cnt = 0;

  always #5 clk = ~clk;

  pc_next_unit_if #(.CNT_WIDTH(16)) a ();
  pc_next_unit_if #(.CNT_WIDTH(2))  b ();

  pc_next_unit #(.RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus_if(a)
  );
  pc_next_unit #(.RESET_PC(32'h0), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst2), .bus_if(b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a.stall_i = 1'b0; a.branch_taken_i = 1'b0; a.jump_i = 1'b0;
    a.offset_sl2_i = 32'h0; a.jump_addr_i = 28'h0;
  endtask

  task automatic test_reset();
    clear_a();
    b.stall_i = 1'b1; b.branch_taken_i = 1'b0; b.jump_i = 1'b0;
    b.offset_sl2_i = 32'h0; b.jump_addr_i = 28'h0;
    rst = 1'b1; rst2 = 1'b1;
    step();
    rst = 1'b0; rst2 = 1'b0;
    vec_cnt++; if (a.pc_o !== 32'h0) begin miss_cnt++; $display("FAIL reset_pc got %h exp %h", a.pc_o, 32'h0); end
    vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL reset_flush got %b exp 0", a.flush_o); end
    vec_cnt++; if (a.fault_o !== 1'b0) begin miss_cnt++; $display("FAIL reset_fault got %b exp 0", a.fault_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'h0) begin miss_cnt++; $display("FAIL reset_cnt got %h exp 0", a.redirect_cnt_o); end
    vec_cnt++; if (b.redirect_cnt_o !== 2'd0) begin miss_cnt++; $display("FAIL reset_cnt2 got %h exp 0", b.redirect_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (a.pc_o !== 32'(i * 4)) begin miss_cnt++; $display("FAIL freerun_pc got %h exp %h", a.pc_o, 32'(i * 4)); end
      vec_cnt++; if (a.pc_plus4_o !== 32'(i * 4 + 4)) begin miss_cnt++; $display("FAIL freerun_plus4 got %h exp %h", a.pc_plus4_o, 32'(i * 4 + 4)); end
      vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL freerun_flush got %b exp 0", a.flush_o); end
      step();
    end
  endtask

  task automatic test_branch_neg();
    repeat (12) step();
    vec_cnt++; if (a.pc_o !== 32'h40) begin miss_cnt++; $display("FAIL br_start_pc got %h exp 40", a.pc_o); end
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'hFFFF_FFF0;
    #1;
    vec_cnt++; if (a.branch_target_o !== 32'h34) begin miss_cnt++; $display("FAIL br_target got %h exp 34", a.branch_target_o); end
    step();
    vec_cnt++; if (a.pc_o !== 32'h34) begin miss_cnt++; $display("FAIL br_pc got %h exp 34", a.pc_o); end
    vec_cnt++; if (a.flush_o !== 1'b1) begin miss_cnt++; $display("FAIL br_flush got %b exp 1", a.flush_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd1) begin miss_cnt++; $display("FAIL br_cnt got %h exp 1", a.redirect_cnt_o); end
    step();
    vec_cnt++; if (a.pc_o !== 32'h38) begin miss_cnt++; $display("FAIL br_ignore_pc got %h exp 38", a.pc_o); end
    vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL br_flush_once got %b exp 0", a.flush_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd1) begin miss_cnt++; $display("FAIL br_cnt_hold got %h exp 1", a.redirect_cnt_o); end
    clear_a();
  endtask

  task automatic test_jump_priority();
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h0FFF_FFD0;
    step();
    vec_cnt++; if (a.pc_o !== 32'h1000_000C) begin miss_cnt++; $display("FAIL jmp_setup_pc got %h exp 1000000c", a.pc_o); end
    clear_a();
    step();
    vec_cnt++; if (a.pc_o !== 32'h1000_0010) begin miss_cnt++; $display("FAIL jmp_start_pc got %h exp 10000010", a.pc_o); end
    a.jump_i = 1'b1; a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h4; a.jump_addr_i = 28'h000_0100;
    step();
    vec_cnt++; if (a.pc_o !== 32'h1000_0100) begin miss_cnt++; $display("FAIL jmp_pc got %h exp 10000100", a.pc_o); end
    vec_cnt++; if (a.flush_o !== 1'b1) begin miss_cnt++; $display("FAIL jmp_flush got %b exp 1", a.flush_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd3) begin miss_cnt++; $display("FAIL jmp_cnt got %h exp 3", a.redirect_cnt_o); end
    clear_a();
    step();
    vec_cnt++; if (a.pc_o !== 32'h1000_0104) begin miss_cnt++; $display("FAIL jmp_after_pc got %h exp 10000104", a.pc_o); end
  endtask

  task automatic test_stall();
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'hEFFF_FF14;
    step();
    clear_a();
    step();
    vec_cnt++; if (a.pc_o !== 32'h20) begin miss_cnt++; $display("FAIL stall_start_pc got %h exp 20", a.pc_o); end
    a.stall_i = 1'b1; a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if (a.pc_o !== 32'h20) begin miss_cnt++; $display("FAIL stall_pc got %h exp 20", a.pc_o); end
      vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL stall_flush got %b exp 0", a.flush_o); end
      vec_cnt++; if (a.redirect_cnt_o !== 16'd4) begin miss_cnt++; $display("FAIL stall_cnt got %h exp 4", a.redirect_cnt_o); end
    end
    clear_a();
    step();
    vec_cnt++; if (a.pc_o !== 32'h24) begin miss_cnt++; $display("FAIL stall_resume got %h exp 24", a.pc_o); end
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h0;
    step();
    vec_cnt++; if (a.flush_o !== 1'b1) begin miss_cnt++; $display("FAIL sflush_flush got %b exp 1", a.flush_o); end
    a.branch_taken_i = 1'b0; a.stall_i = 1'b1;
    step();
    vec_cnt++; if (a.pc_o !== 32'h28) begin miss_cnt++; $display("FAIL sflush_pc got %h exp 28", a.pc_o); end
    vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL sflush_noextend got %b exp 0", a.flush_o); end
    a.stall_i = 1'b0;
    step();
    vec_cnt++; if (a.pc_o !== 32'h2C) begin miss_cnt++; $display("FAIL sflush_resume got %h exp 2c", a.pc_o); end
  endtask

  task automatic test_wrap();
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'hFFFF_FFC8;
    step();
    vec_cnt++; if (a.pc_o !== 32'hFFFF_FFF8) begin miss_cnt++; $display("FAIL wrap_setup got %h exp fffffff8", a.pc_o); end
    clear_a();
    step();
    vec_cnt++; if (a.pc_o !== 32'hFFFF_FFFC) begin miss_cnt++; $display("FAIL wrap_pc got %h exp fffffffc", a.pc_o); end
    vec_cnt++; if (a.pc_plus4_o !== 32'h0) begin miss_cnt++; $display("FAIL wrap_plus4 got %h exp 0", a.pc_plus4_o); end
    step();
    vec_cnt++; if (a.pc_o !== 32'h0) begin miss_cnt++; $display("FAIL wrap_next got %h exp 0", a.pc_o); end
  endtask

  task automatic test_fault();
    step(); step();
    vec_cnt++; if (a.pc_o !== 32'h8) begin miss_cnt++; $display("FAIL fault_start_pc got %h exp 8", a.pc_o); end
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h2;
    step();
    vec_cnt++; if (a.fault_o !== 1'b1) begin miss_cnt++; $display("FAIL fault_set got %b exp 1", a.fault_o); end
    vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL fault_noflush got %b exp 0", a.flush_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd6) begin miss_cnt++; $display("FAIL fault_cnt got %h exp 6", a.redirect_cnt_o); end
    a.branch_taken_i = 1'b0; a.jump_i = 1'b1; a.jump_addr_i = 28'h000_0040;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (a.pc_o !== 32'h8) begin miss_cnt++; $display("FAIL fault_pc got %h exp 8", a.pc_o); end
      vec_cnt++; if (a.fault_o !== 1'b1) begin miss_cnt++; $display("FAIL fault_sticky got %b exp 1", a.fault_o); end
      step();
    end
    clear_a();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec_cnt++; if (a.fault_o !== 1'b0) begin miss_cnt++; $display("FAIL fault_clr got %b exp 0", a.fault_o); end
    vec_cnt++; if (a.pc_o !== 32'h0) begin miss_cnt++; $display("FAIL fault_rst_pc got %h exp 0", a.pc_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd0) begin miss_cnt++; $display("FAIL fault_rst_cnt got %h exp 0", a.redirect_cnt_o); end
  endtask

  task automatic test_reset_mid_flush();
    a.branch_taken_i = 1'b1; a.offset_sl2_i = 32'h8;
    step();
    vec_cnt++; if (a.pc_o !== 32'hC) begin miss_cnt++; $display("FAIL rflush_pc got %h exp c", a.pc_o); end
    vec_cnt++; if (a.flush_o !== 1'b1) begin miss_cnt++; $display("FAIL rflush_flush got %b exp 1", a.flush_o); end
    clear_a();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec_cnt++; if (a.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL rflush_clr got %b exp 0", a.flush_o); end
    vec_cnt++; if (a.pc_o !== 32'h0) begin miss_cnt++; $display("FAIL rflush_rst_pc got %h exp 0", a.pc_o); end
    vec_cnt++; if (a.redirect_cnt_o !== 16'd0) begin miss_cnt++; $display("FAIL rflush_cnt got %h exp 0", a.redirect_cnt_o); end
  endtask

  task automatic test_saturation();
    vec_cnt++; if (b.pc_o !== 32'h0) begin miss_cnt++; $display("FAIL sat_start_pc got %h exp 0", b.pc_o); end
    b.stall_i = 1'b0; b.branch_taken_i = 1'b1; b.offset_sl2_i = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      step();
      vec_cnt++; if (b.pc_o !== 32'(8 * k - 4)) begin miss_cnt++; $display("FAIL sat_pc got %h exp %h", b.pc_o, 32'(8 * k - 4)); end
      vec_cnt++; if (b.flush_o !== 1'b1) begin miss_cnt++; $display("FAIL sat_flush got %b exp 1", b.flush_o); end
      vec_cnt++; if (b.redirect_cnt_o !== 2'((k > 3) ? 3 : k)) begin miss_cnt++; $display("FAIL sat_cnt got %h exp %h", b.redirect_cnt_o, 2'((k > 3) ? 3 : k)); end
      step();
      vec_cnt++; if (b.pc_o !== 32'(8 * k)) begin miss_cnt++; $display("FAIL sat_seq_pc got %h exp %h", b.pc_o, 32'(8 * k)); end
      vec_cnt++; if (b.flush_o !== 1'b0) begin miss_cnt++; $display("FAIL sat_flush_once got %b exp 0", b.flush_o); end
    end
    b.branch_taken_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch_neg();
    test_jump_priority();
    test_stall();
    test_wrap();
    test_fault();
    test_reset_mid_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
